// File: rtl/divu_iter.sv
// Iterative restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional signed mode (MIPS DIV semantics) is enabled by defining DIVU_SIGNED_EN.
module divu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIVU_SIGNED_EN
    input  logic             sign,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_sign;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;
    logic [WIDTH-1:0] w_q_fin;
    logic [WIDTH-1:0] w_r_fin;
    logic             w_last;

`ifdef DIVU_SIGNED_EN
    assign w_sign = sign;
`else
    assign w_sign = 1'b0;
`endif

    // Operands are held as magnitudes; sign fix-up is applied on the final iteration.
    assign w_a_neg = w_sign & dividend[WIDTH-1];
    assign w_b_neg = w_sign & divisor[WIDTH-1];
    assign w_a_mag = w_a_neg ? -dividend : dividend;
    assign w_b_mag = w_b_neg ? -divisor : divisor;

    // r_quo starts as the dividend; its MSB feeds the partial remainder each step.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_div};
    assign w_q_bit  = ~w_trial[WIDTH];
    assign w_rem_nx = w_q_bit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_nx = {r_quo[WIDTH-2:0], w_q_bit};
    assign w_q_fin  = r_neg_q ? -w_quo_nx : w_quo_nx;
    assign w_r_fin  = r_neg_r ? -w_rem_nx : w_rem_nx;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_state     <= S_RUN;
                        r_quo       <= w_a_mag;
                        r_div       <= w_b_mag;
                        r_rem       <= '0;
                        r_cnt       <= '0;
                        // A zero divisor keeps the raw all-ones quotient regardless of signs.
                        r_neg_q     <= (w_a_neg ^ w_b_neg) & (divisor != '0);
                        r_neg_r     <= w_a_neg;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state     <= S_DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= w_q_fin;
                        remainder   <= w_r_fin;
                        div_by_zero <= (r_div == '0);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
